// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the byte-command Wishbone master: state encodings,
// command byte field positions and default response codes.
package wb_cmd_master_pkg;

    typedef enum logic [2:0] {
        WBM_IDLE     = 3'd0,
        WBM_GET_DATA = 3'd1,
        WBM_STROBE   = 3'd2,
        WBM_WAIT_ACK = 3'd3,
        WBM_RESPOND  = 3'd4
    } wbm_state_t;

    localparam int WBM_CMD_WE_BIT  = 7;
    localparam int WBM_CMD_ADR_MSB = 3;

    localparam logic [7:0] WBM_RSP_WR_OK_DEF   = 8'h4B;
    localparam logic [7:0] WBM_RSP_TIMEOUT_DEF = 8'hEE;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator driven by a byte command stream; returns one
// response byte per transfer. WB_MASTER_TIMEOUT_EN adds the ack timeout abort.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int         TIMEOUT     = 255,
    parameter logic [7:0] RSP_WR_OK   = WBM_RSP_WR_OK_DEF,
    parameter logic [7:0] RSP_TIMEOUT = WBM_RSP_TIMEOUT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] cmd_dat_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    output logic [7:0] rsp_dat_o,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [3:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    output logic       busy_o
);

    // Both streams use valid/ready: a byte moves on a posedge where valid and
    // ready are both high; the producer holds its byte stable until then.
    wbm_state_t state, state_nxt;
    logic [7:0] rsp_q, rsp_d;
    logic [3:0] adr_q;
    logic       we_q;
    logic [7:0] dat_q;
    logic       timeout_hit;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_dat_i[WBM_CMD_WE_BIT-1:WBM_CMD_ADR_MSB+1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WBM_IDLE;
            rsp_q <= 8'h00;
            adr_q <= 4'h0;
            we_q  <= 1'b0;
            dat_q <= 8'h00;
        end else begin
            state <= state_nxt;
            rsp_q <= rsp_d;
            if (state == WBM_IDLE && cmd_valid_i) begin
                adr_q <= cmd_dat_i[WBM_CMD_ADR_MSB:0];
                we_q  <= cmd_dat_i[WBM_CMD_WE_BIT];
            end
            if (state == WBM_GET_DATA && cmd_valid_i) begin
                dat_q <= cmd_dat_i;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rsp_d       = rsp_q;
        cmd_ready_o = 1'b0;
        cyc_o       = 1'b0;
        stb_o       = 1'b0;
        case (state)
            WBM_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_nxt = cmd_dat_i[WBM_CMD_WE_BIT] ? WBM_GET_DATA : WBM_STROBE;
                end
            end
            WBM_GET_DATA: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_nxt = WBM_STROBE;
                end
            end
            WBM_STROBE: begin
                // A combinational peripheral may ack in the strobe cycle itself.
                cyc_o = 1'b1;
                stb_o = 1'b1;
                if (ack_i) begin
                    rsp_d     = we_q ? RSP_WR_OK : dat_i;
                    state_nxt = WBM_RESPOND;
                end else begin
                    state_nxt = WBM_WAIT_ACK;
                end
            end
            WBM_WAIT_ACK: begin
                cyc_o = 1'b1;
                if (ack_i) begin
                    rsp_d     = we_q ? RSP_WR_OK : dat_i;
                    state_nxt = WBM_RESPOND;
                end else if (timeout_hit) begin
                    rsp_d     = RSP_TIMEOUT;
                    state_nxt = WBM_RESPOND;
                end
            end
            WBM_RESPOND: begin
                if (rsp_ready_i) begin
                    state_nxt = WBM_IDLE;
                end
            end
            default: state_nxt = WBM_IDLE;
        endcase
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state_nxt == WBM_STROBE) begin
            wait_cnt <= '0;
        end else if (state == WBM_WAIT_ACK) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT-th cycle spent in WAIT_ACK.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT == 0) ^ (^RSP_TIMEOUT);
    assign timeout_hit = 1'b0;
`endif

    assign rsp_dat_o   = rsp_q;
    assign rsp_valid_o = (state == WBM_RESPOND);
    assign busy_o      = (state != WBM_IDLE);
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: peripheral model, driver tasks,
// expected-response queue and per-scenario test tasks.
module tb_wb_cmd_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd_dat;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_dat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       cyc_o, stb_o, we_o;
    logic [3:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_dat_i(cmd_dat), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .rsp_dat_o(rsp_dat), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .busy_o(busy)
    );

    // Peripheral: 15 registers at 0..14, address 15 unmapped (never acks).
    logic [7:0] mem [16];
    logic       ack_reg;
    logic [7:0] dat_reg;
    logic       comb_mode = 1'b0;
    logic       stall = 1'b0;
    logic       force_ack = 1'b0;
    logic [7:0] force_dat = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            ack_reg <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            if (cyc_o && stb_o && !stall && adr_o != 4'hF) begin
                if (!comb_mode) begin
                    ack_reg <= 1'b1;
                    dat_reg <= mem[adr_o];
                end
                if (we_o) mem[adr_o] <= dat_o;
            end
        end
    end

    assign ack_i = force_ack | ack_reg |
                   (comb_mode & cyc_o & stb_o & !stall & (adr_o != 4'hF));
    assign dat_i = force_ack ? force_dat : (comb_mode ? mem[adr_o] : dat_reg);

    // Bus monitor
    int         stb_cnt = 0;
    int         wait_cnt = 0;
    int         accept_cnt = 0;
    logic       last_we;
    logic [3:0] last_adr;
    logic [7:0] last_dat;
    logic       prev_stb = 1'b0;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) accept_cnt++;
        if (stb_o) begin
            stb_cnt++;
            last_we  = we_o;
            last_adr = adr_o;
            last_dat = dat_o;
        end
        if (cyc_o && !stb_o) wait_cnt++;
    end

    always @(negedge clk) begin
        if (stb_o) begin
            checks++;
            if (prev_stb) begin
                errors++;
                $display("FAIL stb_width stb_o high 2 cycles in a row at %0t", $time);
            end
        end
        prev_stb = stb_o;
    end

    // Reference model: register image and queue of expected response bytes.
    logic [7:0] exp_mem [16];
    logic [7:0] exp_q [$];

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        exp_mem[a] = d;
        exp_q.push_back(8'h4B);
    endtask

    task automatic model_read(input logic [3:0] a);
        exp_q.push_back(exp_mem[a]);
    endtask

    // Drivers: every task starts and ends at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cmd_dat   = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte %h never accepted", b);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] d, input int delay);
        int n = 0;
        rsp_ready = 1'b0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL get_rsp no response within bound");
            d = 8'hxx;
        end else begin
            repeat (delay) @(negedge clk);
            d = rsp_dat;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_dat = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_dat, cyc_o, stb_o, we_o, adr_o, dat_o, busy} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b rv=%b rd=%h cyc=%b stb=%b we=%b adr=%h dat=%h busy=%b",
                     cmd_ready, rsp_valid, rsp_dat, cyc_o, stb_o, we_o, adr_o, dat_o, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, cyc_o} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_idle rdy=%b busy=%b cyc=%b exp 1 0 0", cmd_ready, busy, cyc_o);
        end
    endtask

    task automatic test_read;
        logic [7:0] r, e;
        int s0;
        model_read(4'h1);
        s0 = stb_cnt;
        cmd_dat = 8'h01;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_ready got %b exp 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({cyc_o, stb_o, we_o, adr_o} !== {1'b1, 1'b1, 1'b0, 4'h1}) begin
            errors++;
            $display("FAIL read_strobe cyc=%b stb=%b we=%b adr=%h exp 1 1 0 1", cyc_o, stb_o, we_o, adr_o);
        end
        @(negedge clk);
        checks++;
        if ({cyc_o, stb_o, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL read_wait cyc=%b stb=%b rv=%b exp 1 0 0", cyc_o, stb_o, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, cyc_o} !== 2'b10) begin
            errors++;
            $display("FAIL read_latency rv=%b cyc=%b exp 1 0 at 3 cycles", rsp_valid, cyc_o);
        end
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL read_data got %h exp %h", r, e);
        end
        checks++;
        if (stb_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL read_stb_count got %0d exp 1", stb_cnt - s0);
        end
    endtask

    task automatic test_write;
        logic [7:0] r, e;
        model_write(4'h2, 8'h34);
        send_byte(8'h82);
        send_byte(8'h34);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL write_rsp got %h exp %h", r, e);
        end
        checks++;
        if ({last_we, last_adr, last_dat} !== {1'b1, 4'h2, 8'h34}) begin
            errors++;
            $display("FAIL write_bus we=%b adr=%h dat=%h exp 1 2 34", last_we, last_adr, last_dat);
        end
        model_read(4'h2);
        send_byte(8'h02);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL write_readback got %h exp %h", r, e);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] r;
`ifdef WB_MASTER_TIMEOUT_EN
        wait_cnt = 0;
        send_byte(8'h0F);
        get_rsp(r, 0);
        checks++;
        if (r !== 8'hEE) begin
            errors++;
            $display("FAIL timeout_rsp got %h exp ee", r);
        end
        checks++;
        if (wait_cnt !== 8) begin
            errors++;
            $display("FAIL timeout_wait_cycles got %0d exp 8", wait_cnt);
        end
        repeat (3) @(negedge clk);
        force_ack = 1'b1;
        force_dat = 8'h99;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rsp_valid, cyc_o} !== 3'b000) begin
            errors++;
            $display("FAIL late_ack busy=%b rv=%b cyc=%b exp 0 0 0", busy, rsp_valid, cyc_o);
        end
`else
        send_byte(8'h0F);
        repeat (40) @(negedge clk);
        checks++;
        if ({busy, cyc_o, rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL wait_forever busy=%b cyc=%b rv=%b exp 1 1 0", busy, cyc_o, rsp_valid);
        end
        force_ack = 1'b1;
        force_dat = 8'h5A;
        @(negedge clk);
        force_ack = 1'b0;
        get_rsp(r, 0);
        checks++;
        if (r !== 8'h5A) begin
            errors++;
            $display("FAIL slow_ack_rsp got %h exp 5a", r);
        end
`endif
    endtask

    task automatic test_backpressure;
        logic [7:0] r, e;
        int a0;
        int n = 0;
        model_read(4'h1);
        send_byte(8'h01);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = exp_q[0];
        cmd_dat = 8'h02;
        cmd_valid = 1'b1;
        a0 = accept_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_dat, cmd_ready} !== {1'b1, e, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cyc%0d rv=%b rd=%h rdy=%b exp 1 %h 0", i, rsp_valid, rsp_dat, cmd_ready, e);
            end
        end
        checks++;
        if (accept_cnt !== a0) begin
            errors++;
            $display("FAIL bp_no_consume accepts got %0d exp %0d", accept_cnt, a0);
        end
        r = rsp_dat;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL bp_rsp got %h exp %h", r, e);
        end
        checks++;
        if ({cmd_ready, accept_cnt == a0} !== 2'b11) begin
            errors++;
            $display("FAIL bp_idle rdy=%b accepts=%0d exp 1 %0d", cmd_ready, accept_cnt, a0);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (accept_cnt !== a0 + 1) begin
            errors++;
            $display("FAIL bp_release accepts got %0d exp %0d", accept_cnt, a0 + 1);
        end
        model_read(4'h2);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL bp_second_rsp got %h exp %h", r, e);
        end
    endtask

    task automatic test_gapped_write;
        logic [7:0] r, e;
        model_write(4'h3, 8'h77);
        send_byte(8'h83);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({cyc_o, busy} !== 2'b01) begin
                errors++;
                $display("FAIL gap_idle cyc%0d cyc=%b busy=%b exp 0 1", i, cyc_o, busy);
            end
        end
        send_byte(8'h77);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL gap_rsp got %h exp %h", r, e);
        end
        checks++;
        if ({last_we, last_adr, last_dat} !== {1'b1, 4'h3, 8'h77}) begin
            errors++;
            $display("FAIL gap_bus we=%b adr=%h dat=%h exp 1 3 77", last_we, last_adr, last_dat);
        end
    endtask

    task automatic test_reset_wait;
        logic [7:0] r, e;
        logic seen;
        stall = 1'b1;
        send_byte(8'h05);
        repeat (3) @(negedge clk);
        checks++;
        if ({cyc_o, busy} !== 2'b11) begin
            errors++;
            $display("FAIL stall_wait cyc=%b busy=%b exp 1 1", cyc_o, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_dat, cyc_o, stb_o, we_o, adr_o, dat_o, busy} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL midreset_outputs rdy=%b rv=%b rd=%h cyc=%b stb=%b we=%b adr=%h dat=%h busy=%b",
                     cmd_ready, rsp_valid, rsp_dat, cyc_o, stb_o, we_o, adr_o, dat_o, busy);
        end
        stall = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_rsp rsp_valid seen=%b exp 0", seen);
        end
        model_read(4'h1);
        send_byte(8'h01);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL midreset_next got %h exp %h", r, e);
        end
    endtask

    task automatic test_comb_ack;
        logic [7:0] r, e;
        int s0;
        comb_mode = 1'b1;
        s0 = stb_cnt;
        model_write(4'h4, 8'hC3);
        send_byte(8'h84);
        send_byte(8'hC3);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL comb_write got %h exp %h", r, e);
        end
        model_read(4'h4);
        send_byte(8'h04);
        get_rsp(r, 0);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL comb_read got %h exp %h", r, e);
        end
        checks++;
        if (stb_cnt - s0 !== 2) begin
            errors++;
            $display("FAIL comb_stb_count got %0d exp 2", stb_cnt - s0);
        end
        comb_mode = 1'b0;
    endtask

    task automatic test_random;
        logic [7:0] r, e, d;
        logic [3:0] a;
        logic       w;
        for (int t = 0; t < 40; t++) begin
            a = 4'($urandom_range(0, 14));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            comb_mode = 1'($urandom_range(0, 1));
            if (w) begin
                model_write(a, d);
                send_byte({1'b1, 3'($urandom), a});
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(d);
            end else begin
                model_read(a);
                send_byte({1'b0, 3'($urandom), a});
            end
            get_rsp(r, $urandom_range(0, 4));
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL rand_rsp t%0d we=%b adr=%h got %h exp %h", t, w, a, r, e);
            end
            checks++;
            if ({last_we, last_adr} !== {w, a} || (w && last_dat !== d)) begin
                errors++;
                $display("FAIL rand_bus t%0d we=%b adr=%h dat=%h exp %b %h %h", t, last_we, last_adr, last_dat, w, a, d);
            end
        end
        comb_mode = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'(i * 7 + 1);
            exp_mem[i] = 8'(i * 7 + 1);
        end
        mem[1]     = 8'h3C;
        exp_mem[1] = 8'h3C;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_backpressure();
        test_gapped_write();
        test_reset_wait();
        test_comb_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
